// File: rtl/seq_bus_datapath.sv
// Single-bus datapath with register file, Y/Z/HI/LO and a micro-sequencer that
// runs each command as Rb->Y, Rc->ALU->Z, Z->Ra (or a shift-add MUL into HI/LO).
module seq_bus_datapath #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 16,
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              clear_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [2:0]        cmd_op_i,
  input  logic [ADDR_W-1:0] cmd_ra_i,
  input  logic [ADDR_W-1:0] cmd_rb_i,
  input  logic [ADDR_W-1:0] cmd_rc_i,
  input  logic              ld_en_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [DATA_W-1:0] bus_out_o,
  output logic [DATA_W-1:0] hi_out_o,
  output logic [DATA_W-1:0] lo_out_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int unsigned     CNT_W = $clog2(DATA_W + 1);
  localparam logic [ADDR_W:0] NREGS = (ADDR_W + 1)'(NUM_REGS);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic [2:0] {S_IDLE, S_TY, S_TZ, S_TMUL, S_WB} state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   y_q, zhi_q, zlo_q, hi_q, lo_q;
  logic [2:0]          op_q;
  logic [ADDR_W-1:0]   ra_q, rb_q, rc_q;
  logic                illegal_q;
  logic [CNT_W-1:0]    mul_cnt_q;
  logic [2*DATA_W-1:0] mcand_q, acc_q, acc_d;
  logic [DATA_W-1:0]   mplier_q;

  logic [DATA_W-1:0]   bus;
  logic [DATA_W-1:0]   alu_d;
  logic                accept, cmd_illegal, ld_ok;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < NREGS;
  endfunction

  assign accept      = cmd_valid_i && (state_q == S_IDLE);
  assign cmd_illegal = (cmd_op_i > OP_MUL) || !addr_ok(cmd_ra_i) ||
                       !addr_ok(cmd_rb_i) || !addr_ok(cmd_rc_i);
  assign ld_ok       = ld_en_i && (state_q == S_IDLE) && addr_ok(ld_addr_i);

  // Shared bus source select
  always_comb begin
    bus = '0;
    case (state_q)
      S_TY:    bus = regs_q[rb_q];
      S_TZ:    bus = regs_q[rc_q];
      S_WB:    bus = zlo_q;
      default: bus = '0;
    endcase
  end

  always_comb begin
    alu_d = '0;
    case (op_q)
      OP_ADD:  alu_d = y_q + bus;
      OP_SUB:  alu_d = y_q - bus;
      OP_AND:  alu_d = y_q & bus;
      OP_OR:   alu_d = y_q | bus;
      default: alu_d = '0;
    endcase
  end

  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      state_q   <= S_IDLE;
      y_q       <= '0;
      zhi_q     <= '0;
      zlo_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      op_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      rc_q      <= '0;
      illegal_q <= 1'b0;
      mul_cnt_q <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      if (ld_ok) regs_q[ld_addr_i] <= ld_data_i;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q      <= cmd_op_i;
            ra_q      <= cmd_ra_i;
            rb_q      <= cmd_rb_i;
            rc_q      <= cmd_rc_i;
            illegal_q <= cmd_illegal;
            state_q   <= cmd_illegal ? S_WB : S_TY;
          end
        end
        S_TY: begin
          y_q     <= bus;
          state_q <= S_TZ;
        end
        S_TZ: begin
          if (op_q == OP_MUL) begin
            mcand_q   <= {{DATA_W{1'b0}}, y_q};
            mplier_q  <= bus;
            acc_q     <= '0;
            mul_cnt_q <= CNT_W'(DATA_W);
            state_q   <= S_TMUL;
          end else begin
            zhi_q   <= '0;
            zlo_q   <= alu_d;
            state_q <= S_WB;
          end
        end
        // One shift-add step per cycle; the last step lands the product in Z
        S_TMUL: begin
          acc_q     <= acc_d;
          mcand_q   <= mcand_q << 1;
          mplier_q  <= mplier_q >> 1;
          mul_cnt_q <= mul_cnt_q - CNT_W'(1);
          if (mul_cnt_q == CNT_W'(1)) begin
            {zhi_q, zlo_q} <= acc_d;
            state_q        <= S_WB;
          end
        end
        S_WB: begin
          if (!illegal_q) begin
            if (op_q == OP_MUL) begin
              hi_q <= zhi_q;
              lo_q <= zlo_q;
            end else begin
              regs_q[ra_q] <= zlo_q;
            end
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready_o = (state_q == S_IDLE) && !clear_i;
  assign rd_data_o   = addr_ok(rd_addr_i) ? regs_q[rd_addr_i] : '0;
  assign bus_out_o   = bus;
  assign hi_out_o    = hi_q;
  assign lo_out_o    = lo_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_WB) && !clear_i;
  assign err_o       = done_o && illegal_q;

endmodule

// File: tb/tb_seq_bus_datapath.sv
// Directed bench for seq_bus_datapath (DATA_W=32, NUM_REGS=12): table of ALU
// commands plus hand sequences for MUL, back-to-back issue, illegal and abort.
module tb_seq_bus_datapath;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 12;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          clear;
  logic          cmd_valid, cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_ra, cmd_rb, cmd_rc;
  logic          ld_en;
  logic [AW-1:0] ld_addr, rd_addr;
  logic [DW-1:0] ld_data, rd_data, bus_out, hi_out, lo_out;
  logic          busy, done, err;

  seq_bus_datapath #(.DATA_W(DW), .NUM_REGS(NR)) u_dut (
    .clk_i(clk), .clear_i(clear),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_ra_i(cmd_ra), .cmd_rb_i(cmd_rb), .cmd_rc_i(cmd_rc),
    .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .bus_out_o(bus_out),
    .hi_out_o(hi_out), .lo_out_o(lo_out),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] bus_hist [0:127];

  typedef struct {
    logic [2:0]    op;
    logic [AW-1:0] ra, rb, rc;
    logic [DW-1:0] vb, vc, exp;
  } vec_t;

  typedef struct {
    logic [2:0]    op;
    logic [AW-1:0] ra, rb, rc;
  } ill_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic rd_now(input logic [AW-1:0] a, output logic [DW-1:0] v);
    rd_addr = a;
    #1;
    v = rd_data;
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] v);
    @(negedge clk);
    rd_now(a, v);
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] v;
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
    rd_now(a, v);
    chk("load", v, d);
  endtask

  // Polls done from cycle 'start' onward; cyc = 0 if it never arrives
  task automatic wait_done(input int start, output int cyc, output logic e);
    cyc = 0;
    e = 1'b0;
    for (int n = start; n < start + 60; n++) begin
      bus_hist[n] = bus_out;
      if (done) begin
        cyc = n;
        e = err;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [AW-1:0] ra, rb, rc,
                        output int cyc, output logic e);
    cmd_valid = 1'b1; cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rc = rc;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(1, cyc, e);
  endtask

  initial begin
    vec_t          vecs [7];
    ill_t          ills [5];
    int            cyc;
    logic          e, dseen;
    logic [DW-1:0] v, r1_before, hi_before, lo_before;

    vecs[0] = '{3'b000, 4'd5,  4'd1,  4'd2,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[1] = '{3'b001, 4'd6,  4'd2,  4'd1,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0002};
    vecs[2] = '{3'b010, 4'd8,  4'd3,  4'd4,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234};
    vecs[3] = '{3'b011, 4'd9,  4'd3,  4'd4,  32'h8000_0001, 32'h0000_1000, 32'h8000_1001};
    vecs[4] = '{3'b000, 4'd7,  4'd7,  4'd7,  32'h0000_0010, 32'h0000_0010, 32'h0000_0020};
    vecs[5] = '{3'b001, 4'd0,  4'd10, 4'd11, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE};
    vecs[6] = '{3'b000, 4'd11, 4'd0,  4'd0,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFE};

    ills[0] = '{3'b111, 4'd1,  4'd1,  4'd1};
    ills[1] = '{3'b101, 4'd1,  4'd1,  4'd1};
    ills[2] = '{3'b000, 4'd1,  4'd1,  4'd13};
    ills[3] = '{3'b000, 4'd12, 4'd1,  4'd2};
    ills[4] = '{3'b001, 4'd1,  4'd15, 4'd2};

    clear = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_rc = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;

    // Reset
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_bus", bus_out, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi_out, 0);
    chk("rst_lo", lo_out, 0);
    for (int i = 0; i < NR; i++) begin
      rd_now(AW'(i), v);
      chk("rst_reg", v, 0);
    end
    clear = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1);
    load(4'd3, 32'h0000_0005);
    load(4'd4, 32'h0000_0007);
    rd_now(4'd13, v);
    chk("rd_out_of_range", v, 0);

    // Table of ALU commands
    for (int i = 0; i < 7; i++) begin
      load(vecs[i].rb, vecs[i].vb);
      if (vecs[i].rc != vecs[i].rb) load(vecs[i].rc, vecs[i].vc);
      do_cmd(vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].rc, cyc, e);
      chk("alu_done_cycle", 64'(cyc), 3);
      chk("alu_err", e, 0);
      if (i == 0) begin
        chk("add_bus_ty", bus_hist[1], 32'hFFFF_FFFF);
        chk("add_bus_tz", bus_hist[2], 32'h0000_0001);
        chk("add_bus_wb", bus_hist[3], 32'h0000_0000);
      end
      @(negedge clk);
      chk("alu_ready_next", cmd_ready, 1);
      chk("alu_busy_next", busy, 0);
      rd_now(vecs[i].ra, v);
      chk("alu_result", v, vecs[i].exp);
    end

    // Back-to-back with cmd_valid held; ld while busy ignored; load+accept same edge
    load(4'd3, 32'h0000_0100);
    load(4'd4, 32'h0000_0023);
    cmd_valid = 1'b1; cmd_op = 3'b000; cmd_ra = 4'd8; cmd_rb = 4'd3; cmd_rc = 4'd4;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      chk("b2b_ready", cmd_ready, (n == 4) ? 1 : 0);
      chk("b2b_done", done, (n == 3) ? 1 : 0);
      chk("b2b_busy", busy, (n <= 3) ? 1 : 0);
      if (n == 1) begin ld_en = 1'b1; ld_addr = 4'd9; ld_data = 32'hDEAD_BEEF; end
      if (n == 2) ld_en = 1'b0;
      if (n == 4) begin
        cmd_op = 3'b001; cmd_ra = 4'd10;
        ld_en = 1'b1; ld_addr = 4'd4; ld_data = 32'h0000_0003;
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0; ld_en = 1'b0;
    chk("b2b_second_accepted", busy, 1);
    rd_now(4'd8, v);
    chk("b2b_first_result", v, 32'h0000_0123);
    rd_now(4'd4, v);
    chk("load_with_accept", v, 32'h0000_0003);
    wait_done(5, cyc, e);
    chk("b2b_second_done_cycle", 64'(cyc), 7);
    @(negedge clk);
    rd_now(4'd10, v);
    chk("b2b_second_result", v, 32'h0000_00FD);
    rd_now(4'd9, v);
    chk("ld_busy_ignored", v, 32'h8000_1001);

    // MUL full width
    load(4'd5, 32'hABCD_0123);
    load(4'd1, 32'hFFFF_FFFF);
    load(4'd2, 32'hFFFF_FFFF);
    do_cmd(3'b100, 4'd5, 4'd1, 4'd2, cyc, e);
    chk("mul_done_cycle", 64'(cyc), 35);
    chk("mul_err", e, 0);
    chk("mul_bus_tz", bus_hist[2], 32'hFFFF_FFFF);
    chk("mul_bus_tmul", bus_hist[10], 0);
    chk("mul_hi_before_wb", hi_out, 0);
    @(negedge clk);
    chk("mul_hi", hi_out, 32'hFFFF_FFFE);
    chk("mul_lo", lo_out, 32'h0000_0001);
    rd_now(4'd5, v);
    chk("mul_ra_unchanged", v, 32'hABCD_0123);
    load(4'd3, 32'h8000_0000);
    load(4'd4, 32'h0000_0002);
    do_cmd(3'b100, 4'd0, 4'd3, 4'd4, cyc, e);
    chk("mul2_done_cycle", 64'(cyc), 35);
    @(negedge clk);
    chk("mul2_hi", hi_out, 32'h0000_0001);
    chk("mul2_lo", lo_out, 32'h0000_0000);

    // Illegal commands
    for (int i = 0; i < 5; i++) begin
      rd(4'd1, r1_before);
      hi_before = hi_out;
      lo_before = lo_out;
      do_cmd(ills[i].op, ills[i].ra, ills[i].rb, ills[i].rc, cyc, e);
      chk("ill_done_cycle", 64'(cyc), 1);
      chk("ill_err", e, 1);
      @(negedge clk);
      chk("ill_ready_cycle2", cmd_ready, 1);
      chk("ill_hi", hi_out, hi_before);
      chk("ill_lo", lo_out, lo_before);
      rd_now(4'd1, v);
      chk("ill_reg_unchanged", v, r1_before);
    end

    // Clear in the 10th T_MUL cycle
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'b100; cmd_ra = 4'd5; cmd_rb = 4'd1; cmd_rc = 4'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    dseen = 1'b0;
    for (int n = 1; n < 12; n++) begin
      if (done) dseen = 1'b1;
      @(negedge clk);
    end
    chk("abort_busy_before", busy, 1);
    chk("abort_bus_tmul", bus_out, 0);
    clear = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_ready_in_clear", cmd_ready, 0);
    chk("abort_hi", hi_out, 0);
    chk("abort_lo", lo_out, 0);
    clear = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", cmd_ready, 1);
    for (int i = 0; i < NR; i++) begin
      rd_now(AW'(i), v);
      chk("abort_reg", v, 0);
      if (done) dseen = 1'b1;
      @(negedge clk);
    end
    for (int n = 0; n < 40; n++) begin
      if (done) dseen = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_done", dseen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
